// File: rtl/sys_pkg.sv
// Shared types and default divisors for the system reset / clock-enable block.
// Divisors assume a 48 MHz system clock.
package sys_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } sys_state_t;

  localparam int CEN_6M_DIV = 8;
  localparam int CEN_4M_DIV = 12;

  localparam int HOLD_W = 16;
  localparam int DIV_W  = 8;

endpackage

// File: rtl/cen_div.sv
// Free-running clock-enable divider, held at zero while clr is high.
// cen pulses on the last cycle of every DIV-cycle period after clr drops.
module cen_div
  import sys_pkg::*;
#(
  parameter int DIV = CEN_6M_DIV
) (
  input  logic clk,
  input  logic clr,
  output logic cen
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == LAST);

  // cnt runs one ahead of the cycle index so cen can be registered
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      cen <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + DIV_W'(1);
      cen <= wrap;
    end
  end

endmodule

// File: rtl/sys_reset_cen.sv
// PLL-lock driven core reset sequencer with two clock-enable dividers.
// Define PLL_LOSS_RECOVER_EN to drop back to WAIT_LOCK on loss of lock in RUN.
module sys_reset_cen
  import sys_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int CEN_A_DIV   = CEN_6M_DIV,
  parameter int CEN_B_DIV   = CEN_4M_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       cen_a,
  output logic       cen_b,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              locked_m;
  logic              locked_s;
  sys_state_t        state;
  sys_state_t        nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              cen_clr;

  always_comb begin
    nxt = state;
    unique case (state)
      WAIT_LOCK: if (locked_s) nxt = HOLD;
      HOLD: begin
        if (!locked_s)
          nxt = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST)
          nxt = RUN;
      end
`ifdef PLL_LOSS_RECOVER_EN
      RUN: if (!locked_s) nxt = WAIT_LOCK;
`else
      RUN: nxt = RUN;
`endif
      default: nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      sys_rst  <= 1'b1;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
      state    <= nxt;
      sys_rst  <= (nxt != RUN);
      if (state == HOLD)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      else
        hold_cnt <= '0;
    end
  end

`ifdef PLL_LOSS_RECOVER_EN
  always_ff @(posedge clk) begin
    if (rst)
      lock_loss_cnt <= '0;
    else if (state == RUN && nxt == WAIT_LOCK && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = '0;
`endif

  // dividers see next state so cen drops the same edge RUN is left
  assign cen_clr = rst || (nxt != RUN);

  cen_div #(.DIV(CEN_A_DIV)) u_div_a (
    .clk (clk),
    .clr (cen_clr),
    .cen (cen_a)
  );

  cen_div #(.DIV(CEN_B_DIV)) u_div_b (
    .clk (clk),
    .clr (cen_clr),
    .cen (cen_b)
  );

endmodule

// File: tb/tb_sys_reset_cen.sv
// Randomized and directed bench for sys_reset_cen against a streak-based model.
// Honours PLL_LOSS_RECOVER_EN to select the expected loss-of-lock behaviour.
module tb_sys_reset_cen;

  localparam int H = 16;
  localparam int A = 8;
  localparam int B = 12;
`ifdef PLL_LOSS_RECOVER_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sys_rst;
  logic       cen_a;
  logic       cen_b;
  logic [7:0] lock_loss_cnt;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  // model state: last two locked samples, consecutive-lock streak,
  // run flag, cycle index inside RUN, loss count
  int d1, d2, streak, c, loss;
  bit run;

  sys_reset_cen #(
    .HOLD_CYCLES (H),
    .CEN_A_DIV   (A),
    .CEN_B_DIV   (B)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .sys_rst       (sys_rst),
    .cen_a         (cen_a),
    .cen_b         (cen_b),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {sys_rst, cen_a, cen_b, lock_loss_cnt};

  function automatic logic [10:0] expv();
    logic ea, eb;
    ea = run && (c % A == A - 1);
    eb = run && (c % B == B - 1);
    return {!run, ea, eb, 8'(loss)};
  endfunction

  task automatic tick(input bit r, input bit lk);
    int ls;
    bit prev;
    rst = r;
    locked = lk;
    @(posedge clk);
    if (r) begin
      d1 = 0; d2 = 0; streak = 0; run = 0; c = 0; loss = 0;
    end else begin
      ls = d2;
      d2 = d1;
      d1 = int'(lk);
      prev = run;
      if (ls != 0) begin
        if (streak < 1000000) streak++;
      end else begin
        streak = 0;
      end
      if (REC) run = (streak >= H + 1);
      else     run = run || (streak >= H + 1);
      if (prev && !run && loss < 255) loss++;
      c = run ? (prev ? c + 1 : 0) : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0);
    tick(1, 1);
    checks++;
    if (obs !== 11'h400) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, 11'h400);
    end
  endtask

  // returns edge number (first locked=1 edge is 1) at which sys_rst fell
  task automatic run_up(input string nm, output int fall);
    fall = -1;
    for (int e = 1; e <= 40 && fall < 0; e++) begin
      tick(0, 1);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL %s e%0d got %h exp %h", nm, e, obs, expv());
      end
      if (sys_rst === 1'b0) fall = e;
    end
  endtask

  task automatic test_startup();
    int fall;
    tick(1, 0);
    run_up("startup", fall);
    checks++;
    if (fall != H + 3) begin
      errors++;
      $display("FAIL startup_edge got %0d exp %0d", fall, H + 3);
    end
  endtask

  task automatic test_run48();
    int na, nb, fa, fb;
    int coin[$];
    na = 0; nb = 0; fa = -1; fb = -1;
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL run48 c%0d got %h exp %h", i, obs, expv());
      end
      if (cen_a === 1'b1) begin na++; if (fa < 0) fa = i; end
      if (cen_b === 1'b1) begin nb++; if (fb < 0) fb = i; end
      if (cen_a === 1'b1 && cen_b === 1'b1) coin.push_back(i);
      tick(0, 1);
    end
    checks++;
    if (na != 6 || nb != 4) begin
      errors++;
      $display("FAIL pulse_count got %0d/%0d exp 6/4", na, nb);
    end
    checks++;
    if (fa != A - 1 || fb != B - 1) begin
      errors++;
      $display("FAIL first_pulse got %0d/%0d exp %0d/%0d", fa, fb, A - 1, B - 1);
    end
    checks++;
    if (coin.size() != 2 || coin[0] != 23 || coin[1] != 47) begin
      errors++;
      $display("FAIL coincide got n=%0d", coin.size());
    end
  endtask

  task automatic test_hold_glitch();
    int fall;
    tick(1, 0);
    // edges 1..13 leave hold_cnt at 10
    for (int e = 1; e <= 13; e++) begin
      tick(0, 1);
      checks++;
      if (obs !== expv() || sys_rst !== 1'b1) begin
        errors++;
        $display("FAIL glitch_pre e%0d got %h exp %h", e, obs, expv());
      end
    end
    tick(0, 0);
    run_up("glitch", fall);
    checks++;
    if (fall != H + 3) begin
      errors++;
      $display("FAIL glitch_edge got %0d exp %0d", fall, H + 3);
    end
  endtask

  task automatic test_lock_loss();
    int fall, rose, np;
    tick(1, 0);
    run_up("loss_up", fall);
    for (int i = 0; i < 5; i++) tick(0, 1);
    rose = -1;
    np = 0;
    tick(0, 0);
    for (int e = 1; e <= 24; e++) begin
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL loss e%0d got %h exp %h", e, obs, expv());
      end
      if (sys_rst === 1'b1 && rose < 0) rose = e;
      if (cen_a === 1'b1 || cen_b === 1'b1) np++;
      tick(0, (e > 2));
    end
    if (REC) begin
      checks++;
      if (rose < 0 || rose > 3 || lock_loss_cnt !== 8'd1) begin
        errors++;
        $display("FAIL loss_rec rose %0d cnt %0d exp <=3/1", rose, lock_loss_cnt);
      end
      for (int k = 1; k < 300; k++) begin
        run_up("loss_relock", fall);
        tick(0, 0);
      end
      for (int e = 0; e < 4; e++) tick(0, 1);
      checks++;
      if (lock_loss_cnt !== 8'd255) begin
        errors++;
        $display("FAIL loss_sat got %0d exp 255", lock_loss_cnt);
      end
    end else begin
      checks++;
      if (rose >= 0 || np < 4 || lock_loss_cnt !== 8'd0) begin
        errors++;
        $display("FAIL loss_norec rose %0d pulses %0d cnt %0d", rose, np, lock_loss_cnt);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    int fall;
    tick(1, 0);
    run_up("mid_up", fall);
    for (int i = 0; i < 10; i++) tick(0, 1);
    tick(1, 1);
    checks++;
    if (obs !== 11'h400) begin
      errors++;
      $display("FAIL mid_rst got %h exp %h", obs, 11'h400);
    end
    run_up("mid_restart", fall);
    checks++;
    if (fall != H + 3) begin
      errors++;
      $display("FAIL mid_edge got %0d exp %0d", fall, H + 3);
    end
  endtask

  task automatic test_random();
    bit lk, r;
    lk = 1'b1;
    tick(1, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = !lk;
      r = ($urandom_range(0, 599) == 0);
      tick(r, lk);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random i%0d got %h exp %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    d1 = 0; d2 = 0; streak = 0; run = 0; c = 0; loss = 0;
    test_reset();
    test_startup();
    test_run48();
    test_hold_glitch();
    test_lock_loss();
    test_rst_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
